// File: rtl/subroutine_stack_ctrl_pkg.sv
// Shared types and codes for the subroutine call/return sequencer.
// State encodings, fault codes and instruction patterns.
package subroutine_stack_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALL   = 2'd1,
    ST_RETURN = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UNF  = 2'b10;

  localparam logic [11:0] BSR_OPCODE = 12'b011100000000;
  localparam logic [21:0] RET_CODE   =
    22'b0000011000000000000000;

  typedef struct packed {
    logic stb;
    logic bsr;
    logic ret;
  } ir_flags_t;

  // Fault code raised when leaving the given state into FAULT
  function automatic logic [1:0] fault_code(
    input state_t s
  );
    return (s == ST_CALL) ? ERR_OVF : ERR_UNF;
  endfunction

endpackage

// File: rtl/subroutine_stack_ctrl_lifo.sv
// Return-address LIFO: DEPTH x AW storage, top pointer, count.
// WRAP_EN=1 makes it circular: a push when full drops the oldest entry.
module subroutine_stack_ctrl_lifo
  import subroutine_stack_ctrl_pkg::*;
#(
  parameter int AW      = 10,
  parameter int DEPTH   = 8,
  parameter bit WRAP_EN = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [AW-1:0]            wr_data,
  output logic [AW-1:0]            rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] top;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

  assign do_push = rst_n && !clr && push
                && (!full || WRAP_EN);
  assign do_pop  = !clr && pop && !push && !empty;

  // top always names the next free slot
  assign rd_data = mem[top - 1'b1];

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      top <= '0;
      cnt <= '0;
    end else if (do_push) begin
      top <= top + 1'b1;
      if (!full)
        cnt <= cnt + 1'b1;
    end else if (do_pop) begin
      top <= top - 1'b1;
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[top] <= wr_data;
  end

endmodule

// File: rtl/subroutine_stack_ctrl.sv
// Call/return sequencer between IR and PC/fetch; stalls fetch on redirect.
// Define SUBSTACK_WRAP_EN for a circular return stack (no overflow fault).
module subroutine_stack_ctrl
  import subroutine_stack_ctrl_pkg::*;
#(
  parameter int AW    = 10,
  parameter int DEPTH = 8
) (
  input  logic                    CLK,
  input  logic                    RST_n,
  input  logic                    HOLD,
  input  logic                    IR_strobe,
  input  logic [21:0]             IR_code,
  input  logic                    bsr_det,
  input  logic                    ret_det,
  input  logic [AW-1:0]           PC_in,
  input  logic                    clr_err,
  output logic [AW-1:0]           PC_target,
  output logic                    PC_load,
  output logic                    HOLD_req,
  output logic                    stack_err,
  output logic [1:0]              err_code,
  output logic [$clog2(DEPTH):0]  sp_count
);

`ifdef SUBSTACK_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  state_t        state;
  state_t        state_nx;
  ir_flags_t     ir;
  logic [AW-1:0] ret_addr;
  logic [AW-1:0] top_addr;
  logic          lifo_push;
  logic          lifo_pop;
  logic          lifo_clr;
  logic          lifo_full;
  logic          lifo_empty;
  logic          unused_ir;

  assign ir        = '{stb: IR_strobe,
                       bsr: bsr_det,
                       ret: ret_det};
  assign ret_addr  = PC_in + 1'b1;
  assign unused_ir = ^IR_code[21:AW];

  subroutine_stack_ctrl_lifo #(
    .AW      (AW),
    .DEPTH   (DEPTH),
    .WRAP_EN (WRAP_EN)
  ) u_lifo (
    .clk     (CLK),
    .rst_n   (RST_n),
    .clr     (lifo_clr),
    .push    (lifo_push),
    .pop     (lifo_pop),
    .wr_data (ret_addr),
    .rd_data (top_addr),
    .count   (sp_count),
    .full    (lifo_full),
    .empty   (lifo_empty)
  );

  always_ff @(posedge CLK) begin
    if (!RST_n)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!HOLD) begin
      unique case (state)
        ST_IDLE: begin
          if (ir.stb) begin
            // ret wins when both flags are set
            priority case (1'b1)
              ir.ret:  state_nx = ST_RETURN;
              ir.bsr:  state_nx = ST_CALL;
              default: state_nx = ST_IDLE;
            endcase
          end
        end
        ST_CALL:
          state_nx = (lifo_full && !WRAP_EN)
                   ? ST_FAULT : ST_IDLE;
        ST_RETURN:
          state_nx = lifo_empty
                   ? ST_FAULT : ST_IDLE;
        ST_FAULT:
          if (clr_err)
            state_nx = ST_IDLE;
        default:
          state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    lifo_push = 1'b0;
    lifo_pop  = 1'b0;
    lifo_clr  = 1'b0;
    PC_load   = 1'b0;
    HOLD_req  = 1'b0;
    stack_err = 1'b0;
    unique case (state)
      ST_IDLE: ;
      ST_CALL: begin
        HOLD_req  = 1'b1;
        lifo_push = !HOLD
                 && (!lifo_full || WRAP_EN);
        PC_load   = lifo_push;
      end
      ST_RETURN: begin
        HOLD_req = 1'b1;
        lifo_pop = !HOLD && !lifo_empty;
        PC_load  = lifo_pop;
      end
      ST_FAULT: begin
        HOLD_req  = 1'b1;
        stack_err = 1'b1;
        lifo_clr  = !HOLD && clr_err;
      end
      default: ;
    endcase
  end

  // Target is latched at the strobe so it is valid during the redirect cycle
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      PC_target <= '0;
      err_code  <= ERR_NONE;
    end else if (!HOLD) begin
      if (state == ST_IDLE && ir.stb) begin
        if (ir.ret) begin
          if (!lifo_empty)
            PC_target <= top_addr;
        end else if (ir.bsr) begin
          PC_target <= IR_code[AW-1:0];
        end
      end
      if (state != ST_FAULT
          && state_nx == ST_FAULT)
        err_code <= fault_code(state);
      if (lifo_clr)
        err_code <= ERR_NONE;
    end
  end

endmodule

// File: tb/tb_subroutine_stack_ctrl.sv
// Directed bench for subroutine_stack_ctrl: vector table plus
// hand sequences for nesting, wrap/overflow and reset mid-call.
module tb_subroutine_stack_ctrl;

  logic        CLK;
  logic        RST_n;
  logic        HOLD;
  logic        IR_strobe;
  logic [21:0] IR_code;
  logic        bsr_det;
  logic        ret_det;
  logic [9:0]  PC_in;
  logic        clr_err;
  logic [9:0]  PC_target;
  logic        PC_load;
  logic        HOLD_req;
  logic        stack_err;
  logic [1:0]  err_code;
  logic [3:0]  sp_count;

  int n_vec = 0;
  int n_err = 0;

`ifdef SUBSTACK_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  subroutine_stack_ctrl #(
    .AW    (10),
    .DEPTH (8)
  ) dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .HOLD      (HOLD),
    .IR_strobe (IR_strobe),
    .IR_code   (IR_code),
    .bsr_det   (bsr_det),
    .ret_det   (ret_det),
    .PC_in     (PC_in),
    .clr_err   (clr_err),
    .PC_target (PC_target),
    .PC_load   (PC_load),
    .HOLD_req  (HOLD_req),
    .stack_err (stack_err),
    .err_code  (err_code),
    .sp_count  (sp_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic       hold;
    logic       stb;
    logic       bsr;
    logic       ret;
    logic       clr;
    logic [9:0] code;
    logic [9:0] pc;
    logic       e_load;
    logic [9:0] e_tgt;
    logic       e_hreq;
    logic       e_err;
    logic [1:0] e_code;
    logic [3:0] e_sp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic r, h, s, b, t, c,
    input logic [9:0] code, pc,
    input logic ld,
    input logic [9:0] tgt,
    input logic hr, er,
    input logic [1:0] ec,
    input logic [3:0] sp
  );
    vec_t v;
    v.rst = r;   v.hold = h;
    v.stb = s;   v.bsr = b;
    v.ret = t;   v.clr = c;
    v.code = code; v.pc = pc;
    v.e_load = ld; v.e_tgt = tgt;
    v.e_hreq = hr; v.e_err = er;
    v.e_code = ec; v.e_sp = sp;
    return v;
  endfunction

  task automatic chk(
    input string nm,
    input int idx,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h want %0h",
               nm, idx, act, exp);
    end
  endtask

  // Inputs change at negedge; outputs of that cycle are sampled 1ns later
  task automatic cyc(
    input logic r, h, s, b, t, c,
    input logic [9:0] code, pc
  );
    @(negedge CLK);
    RST_n     = r;
    HOLD      = h;
    IR_strobe = s;
    bsr_det   = b;
    ret_det   = t;
    clr_err   = c;
    IR_code   = {12'h000, code};
    PC_in     = pc;
    #1;
  endtask

  task automatic chk_all(
    input string nm, input int idx,
    input logic ld, input logic [9:0] tgt,
    input logic hr, er,
    input logic [1:0] ec, input logic [3:0] sp
  );
    chk({nm, "_load"}, idx, 32'(PC_load), 32'(ld));
    chk({nm, "_hreq"}, idx, 32'(HOLD_req), 32'(hr));
    chk({nm, "_err"},  idx, 32'(stack_err), 32'(er));
    chk({nm, "_code"}, idx, 32'(err_code), 32'(ec));
    chk({nm, "_sp"},   idx, 32'(sp_count), 32'(sp));
    if (ld)
      chk({nm, "_tgt"}, idx, 32'(PC_target), 32'(tgt));
  endtask

  initial begin
    RST_n = 1'b0; HOLD = 1'b0;
    IR_strobe = 1'b0; bsr_det = 1'b0;
    ret_det = 1'b0; clr_err = 1'b0;
    IR_code = '0; PC_in = '0;

    //          r h s b t c code   pc     | ld tgt    hr er ec sp
    tbl.push_back(mk(1,0,0,0,0,0,10'h000,10'h000, 0,10'h000,0,0,0,0));
    tbl.push_back(mk(1,0,1,1,0,0,10'h155,10'h020, 0,10'h000,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,10'h155,10'h020, 1,10'h155,1,0,0,0));
    tbl.push_back(mk(1,0,1,0,1,0,10'h000,10'h000, 0,10'h000,0,0,0,1));
    tbl.push_back(mk(1,0,0,0,0,0,10'h000,10'h000, 1,10'h021,1,0,0,1));
    tbl.push_back(mk(1,0,1,0,1,0,10'h000,10'h000, 0,10'h000,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,10'h000,10'h000, 0,10'h000,1,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,10'h000,10'h000, 0,10'h000,1,1,2,0));
    tbl.push_back(mk(1,0,0,0,0,1,10'h000,10'h000, 0,10'h000,1,1,2,0));
    tbl.push_back(mk(1,0,0,0,0,0,10'h000,10'h000, 0,10'h000,0,0,0,0));
    tbl.push_back(mk(1,0,1,1,0,0,10'h2AA,10'h3FF, 0,10'h000,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,10'h2AA,10'h3FF, 0,10'h000,1,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,10'h2AA,10'h3FF, 0,10'h000,1,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,10'h2AA,10'h3FF, 0,10'h000,1,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,10'h2AA,10'h3FF, 1,10'h2AA,1,0,0,0));
    tbl.push_back(mk(1,0,1,0,1,0,10'h000,10'h000, 0,10'h000,0,0,0,1));
    tbl.push_back(mk(1,0,0,0,0,0,10'h000,10'h000, 1,10'h000,1,0,0,1));
    tbl.push_back(mk(1,0,0,0,0,0,10'h000,10'h000, 0,10'h000,0,0,0,0));
    tbl.push_back(mk(1,1,1,1,0,0,10'h100,10'h000, 0,10'h000,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,10'h000,10'h000, 0,10'h000,0,0,0,0));
    tbl.push_back(mk(1,0,1,1,0,0,10'h0AB,10'h010, 0,10'h000,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,10'h0AB,10'h010, 1,10'h0AB,1,0,0,0));
    tbl.push_back(mk(1,0,1,1,1,0,10'h0CD,10'h011, 0,10'h000,0,0,0,1));
    tbl.push_back(mk(1,0,0,0,0,0,10'h000,10'h000, 1,10'h011,1,0,0,1));
    tbl.push_back(mk(1,0,0,0,0,0,10'h000,10'h000, 0,10'h000,0,0,0,0));

    repeat (2) @(posedge CLK);
    cyc(0,0,0,0,0,0,10'h000,10'h000);
    chk_all("rst", 0, 1'b0, 10'h000,
            1'b0, 1'b0, 2'd0, 4'd0);
    chk("rst_tgt", 0, 32'(PC_target), 32'h0);

    foreach (tbl[i]) begin
      cyc(tbl[i].rst, tbl[i].hold, tbl[i].stb,
          tbl[i].bsr, tbl[i].ret, tbl[i].clr,
          tbl[i].code, tbl[i].pc);
      chk_all("vec", i, tbl[i].e_load, tbl[i].e_tgt,
              tbl[i].e_hreq, tbl[i].e_err,
              tbl[i].e_code, tbl[i].e_sp);
    end

    // Nine nested calls into an 8-deep stack
    for (int i = 0; i < 9; i++) begin
      logic exp_ld;
      cyc(1,0,1,1,0,0,10'(10'h100 + i),10'(i));
      cyc(1,0,0,0,0,0,10'(10'h100 + i),10'(i));
      exp_ld = (i < 8) || WRAP;
      chk("nest_load", i, 32'(PC_load), 32'(exp_ld));
      if (exp_ld)
        chk("nest_tgt", i, 32'(PC_target),
            32'(10'h100 + i));
    end
    cyc(1,0,0,0,0,0,10'h000,10'h000);
`ifdef SUBSTACK_WRAP_EN
    chk_all("wrap", 0, 1'b0, 10'h000,
            1'b0, 1'b0, 2'd0, 4'd8);
    for (int j = 0; j < 8; j++) begin
      cyc(1,0,1,0,1,0,10'h000,10'h000);
      cyc(1,0,0,0,0,0,10'h000,10'h000);
      chk("wrap_load", j, 32'(PC_load), 32'h1);
      chk("wrap_tgt", j, 32'(PC_target), 32'(9 - j));
    end
    cyc(1,0,0,0,0,0,10'h000,10'h000);
    chk("wrap_sp", 0, 32'(sp_count), 32'h0);
`else
    chk_all("ovf", 0, 1'b0, 10'h000,
            1'b1, 1'b1, 2'd1, 4'd8);
    cyc(1,0,0,0,0,0,10'h000,10'h000);
    chk_all("ovf", 1, 1'b0, 10'h000,
            1'b1, 1'b1, 2'd1, 4'd8);
    cyc(1,0,0,0,0,1,10'h000,10'h000);
    cyc(1,0,0,0,0,0,10'h000,10'h000);
    chk_all("ovf_clr", 0, 1'b0, 10'h000,
            1'b0, 1'b0, 2'd0, 4'd0);
`endif

    // Reset asserted during the CALL cycle
    cyc(1,0,1,1,0,0,10'h3C3,10'h050);
    cyc(0,0,0,0,0,0,10'h3C3,10'h050);
    cyc(1,0,0,0,0,0,10'h000,10'h000);
    chk_all("rstcall", 0, 1'b0, 10'h000,
            1'b0, 1'b0, 2'd0, 4'd0);
    chk("rstcall_tgt", 0, 32'(PC_target), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
